// File: rtl/fb_mem_responder.sv
// fb_mem_responder: drains the single-command and burst-read command FIFOs
// onto a 16-bit memory port and returns read data to the matching reader FIFO.
// Burst requests have priority. A burst read collects BURST_LEN beats into one
// wide word before pushing it.
// Optional feature: define FB_MEM_RESPONDER_STATS_EN to add saturating
// counters of completed single and burst transactions.
module fb_mem_responder #(
    parameter int BURST_LEN = 8
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [40:0]             writer_q_i,
    output logic                    writer_deq_o,
    input  logic                    writer_empty_i,
    input  logic [31:0]             writer_burst_q_i,
    output logic                    writer_burst_deq_o,
    input  logic                    writer_burst_empty_i,
    output logic [15:0]             reader_d_o,
    output logic                    reader_enq_o,
    input  logic                    reader_full_i,
    output logic [16*BURST_LEN-1:0] reader_burst_d_o,
    output logic                    reader_burst_enq_o,
    input  logic                    reader_burst_full_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic                    mem_burst_o,
    output logic [23:0]             mem_addr_o,
    output logic [15:0]             mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic                    mem_rvalid_i,
    input  logic [15:0]             mem_rdata_i
`ifdef FB_MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]             stat_single_o,
    output logic [15:0]             stat_burst_o
`endif
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_BEAT  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_SINGLE,
        COLLECT,
        PUSH_BURST
    } state_t;

    state_t state;
    state_t state_next;

    logic             sel_burst;
    logic             sel_single;
    logic [CNT_W-1:0] beat_cnt;
    logic [7:0]       unused_burst_hi;

    // The top byte of a burst request carries nothing this block needs.
    assign unused_burst_hi = writer_burst_q_i[31:24];

    // Arbitration: a burst wins whenever its destination has room; a single
    // read also needs room in the single-read FIFO, a single write does not.
    always_comb begin
        sel_burst  = !writer_burst_empty_i && !reader_burst_full_i;
        sel_single = !sel_burst && !writer_empty_i &&
                     (writer_q_i[40] || !reader_full_i);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the single-cycle handshake pulses; all pulses are
    // held low while reset is asserted so nothing is popped or pushed then.
    always_comb begin
        state_next         = state;
        writer_deq_o       = 1'b0;
        writer_burst_deq_o = 1'b0;
        mem_req_o          = 1'b0;
        reader_burst_enq_o = 1'b0;
        case (state)
            IDLE: begin
                if (sel_burst) begin
                    writer_burst_deq_o = 1'b1;
                    state_next         = REQ;
                end else if (sel_single) begin
                    writer_deq_o = 1'b1;
                    state_next   = REQ;
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    if (mem_we_o) begin
                        state_next = IDLE;
                    end else if (mem_burst_o) begin
                        state_next = COLLECT;
                    end else begin
                        state_next = WAIT_SINGLE;
                    end
                end
            end
            WAIT_SINGLE: begin
                if (mem_rvalid_i) begin
                    state_next = IDLE;
                end
            end
            COLLECT: begin
                if (mem_rvalid_i && (beat_cnt == LAST_BEAT)) begin
                    state_next = PUSH_BURST;
                end
            end
            PUSH_BURST: begin
                reader_burst_enq_o = 1'b1;
                state_next         = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (reset_i) begin
            writer_deq_o       = 1'b0;
            writer_burst_deq_o = 1'b0;
            mem_req_o          = 1'b0;
            reader_burst_enq_o = 1'b0;
        end
    end

    // Datapath: latch the selected command, capture single and burst read
    // beats, and generate the registered single-read push.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            mem_we_o         <= 1'b0;
            mem_burst_o      <= 1'b0;
            mem_addr_o       <= '0;
            mem_wdata_o      <= '0;
            beat_cnt         <= '0;
            reader_d_o       <= '0;
            reader_enq_o     <= 1'b0;
            reader_burst_d_o <= '0;
        end else begin
            reader_enq_o <= 1'b0;
            if (writer_burst_deq_o) begin
                mem_we_o    <= 1'b0;
                mem_burst_o <= 1'b1;
                mem_addr_o  <= writer_burst_q_i[23:0];
                mem_wdata_o <= '0;
            end else if (writer_deq_o) begin
                mem_we_o    <= writer_q_i[40];
                mem_burst_o <= 1'b0;
                mem_addr_o  <= writer_q_i[39:16];
                mem_wdata_o <= writer_q_i[15:0];
            end
            if ((state == REQ) && mem_ack_i) begin
                beat_cnt <= '0;
            end
            if ((state == WAIT_SINGLE) && mem_rvalid_i) begin
                reader_d_o   <= mem_rdata_i;
                reader_enq_o <= 1'b1;
            end
            if ((state == COLLECT) && mem_rvalid_i) begin
                reader_burst_d_o[{beat_cnt, 4'b0000} +: 16] <= mem_rdata_i;
                beat_cnt <= beat_cnt + ONE_BEAT;
            end
        end
    end

`ifdef FB_MEM_RESPONDER_STATS_EN
    logic single_done;
    logic burst_done;

    assign single_done = ((state == REQ) && mem_ack_i && mem_we_o) ||
                         ((state == WAIT_SINGLE) && mem_rvalid_i);
    assign burst_done  = (state == PUSH_BURST);

    // Saturating completion counters; a single completes on write ack or on
    // read data return, a burst completes when its word is pushed.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            stat_single_o <= '0;
            stat_burst_o  <= '0;
        end else begin
            if (single_done && (stat_single_o != 16'hFFFF)) begin
                stat_single_o <= stat_single_o + 16'd1;
            end
            if (burst_done && (stat_burst_o != 16'hFFFF)) begin
                stat_burst_o <= stat_burst_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fb_mem_responder.sv
// tb_fb_mem_responder: directed, self-checking bench for fb_mem_responder.
// Inputs change 1 time unit after the rising edge; a negedge monitor counts
// pulses. Single transactions come from a vector table; bursts, arbitration
// and reset are hand-written sequences.
module tb_fb_mem_responder;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [40:0]  writer_q_i;
    logic         writer_deq_o;
    logic         writer_empty_i;
    logic [31:0]  writer_burst_q_i;
    logic         writer_burst_deq_o;
    logic         writer_burst_empty_i;
    logic [15:0]  reader_d_o;
    logic         reader_enq_o;
    logic         reader_full_i;
    logic [127:0] reader_burst_d_o;
    logic         reader_burst_enq_o;
    logic         reader_burst_full_i;
    logic         mem_req_o;
    logic         mem_we_o;
    logic         mem_burst_o;
    logic [23:0]  mem_addr_o;
    logic [15:0]  mem_wdata_o;
    logic         mem_ack_i;
    logic         mem_rvalid_i;
    logic [15:0]  mem_rdata_i;
`ifdef FB_MEM_RESPONDER_STATS_EN
    logic [15:0]  stat_single_o;
    logic [15:0]  stat_burst_o;
`endif

    fb_mem_responder #(.BURST_LEN(8)) dut (
        .clk                  (clk),
        .reset_i              (reset_i),
        .writer_q_i           (writer_q_i),
        .writer_deq_o         (writer_deq_o),
        .writer_empty_i       (writer_empty_i),
        .writer_burst_q_i     (writer_burst_q_i),
        .writer_burst_deq_o   (writer_burst_deq_o),
        .writer_burst_empty_i (writer_burst_empty_i),
        .reader_d_o           (reader_d_o),
        .reader_enq_o         (reader_enq_o),
        .reader_full_i        (reader_full_i),
        .reader_burst_d_o     (reader_burst_d_o),
        .reader_burst_enq_o   (reader_burst_enq_o),
        .reader_burst_full_i  (reader_burst_full_i),
        .mem_req_o            (mem_req_o),
        .mem_we_o             (mem_we_o),
        .mem_burst_o          (mem_burst_o),
        .mem_addr_o           (mem_addr_o),
        .mem_wdata_o          (mem_wdata_o),
        .mem_ack_i            (mem_ack_i),
        .mem_rvalid_i         (mem_rvalid_i),
        .mem_rdata_i          (mem_rdata_i)
`ifdef FB_MEM_RESPONDER_STATS_EN
        ,
        .stat_single_o        (stat_single_o),
        .stat_burst_o         (stat_burst_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int req_cycles = 0;
    int enq_cnt = 0;
    int benq_cnt = 0;
    int exp_single = 0;
    int exp_burst = 0;
    logic [15:0]  last_rd = '0;
    logic [127:0] last_burst = '0;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
        int          ack_delay;
        logic [15:0] rdata;
        int          rv_delay;
        int          exp_req;
        int          exp_enq;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    // Pulse monitor, sampled mid-cycle where everything is stable.
    always @(negedge clk) begin
        if (mem_req_o) req_cycles++;
        if (reader_enq_o) begin
            enq_cnt++;
            last_rd = reader_d_o;
        end
        if (reader_burst_enq_o) begin
            benq_cnt++;
            last_burst = reader_burst_d_o;
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    task check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task check_all_zero(input string name);
        check({name, "_ctl"}, {writer_deq_o, writer_burst_deq_o, reader_enq_o,
              reader_burst_enq_o, mem_req_o, mem_we_o, mem_burst_o}, 7'b0);
        check({name, "_mem"}, {mem_addr_o, mem_wdata_o}, 40'h0);
        check({name, "_rd"}, reader_d_o, 16'h0);
        check({name, "_burst"}, reader_burst_d_o, 128'h0);
    endtask

    // One single transaction: offer the command, wait for the pop, answer
    // the request after ack_delay cycles, then return read data if a read.
    task automatic do_single(input logic we, input logic [23:0] addr,
                             input logic [15:0] wdata, input int ack_delay,
                             input logic [15:0] rdata, input int rv_delay);
        int n;
        writer_q_i     = {we, addr, wdata};
        writer_empty_i = 1'b0;
        #1;
        n = 0;
        while (!writer_deq_o && n < 20) begin
            tick();
            n++;
        end
        check("single_deq", writer_deq_o, 1'b1);
        if (!writer_deq_o) begin
            writer_empty_i = 1'b1;
            return;
        end
        tick();
        writer_empty_i = 1'b1;
        check("single_req", {mem_req_o, mem_we_o, mem_burst_o, mem_addr_o, mem_wdata_o},
              {1'b1, we, 1'b0, addr, wdata});
        repeat (ack_delay) tick();
        check("single_req_held", {mem_req_o, mem_we_o, mem_burst_o, mem_addr_o, mem_wdata_o},
              {1'b1, we, 1'b0, addr, wdata});
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("single_req_drop", mem_req_o, 1'b0);
        exp_single++;
        if (!we) begin
            repeat (rv_delay) tick();
            mem_rdata_i  = rdata;
            mem_rvalid_i = 1'b1;
            tick();
            mem_rvalid_i = 1'b0;
            #1;
            check("single_rd_push", {reader_enq_o, reader_d_o}, {1'b1, rdata});
            tick();
        end
    endtask

    // One burst read: offer the request, ack it, deliver stop_after beats
    // (gap idle cycles before each) and, for a full burst, check the push.
    task automatic run_burst(input logic [23:0] addr, input logic [127:0] beats,
                             input int ack_delay, input int gap, input int stop_after);
        int n;
        writer_burst_q_i     = {8'hA5, addr};
        writer_burst_empty_i = 1'b0;
        #1;
        n = 0;
        while (!writer_burst_deq_o && n < 20) begin
            tick();
            n++;
        end
        check("burst_deq", writer_burst_deq_o, 1'b1);
        if (!writer_burst_deq_o) begin
            writer_burst_empty_i = 1'b1;
            return;
        end
        tick();
        writer_burst_empty_i = 1'b1;
        check("burst_req", {mem_req_o, mem_we_o, mem_burst_o, mem_addr_o},
              {1'b1, 1'b0, 1'b1, addr});
        repeat (ack_delay) tick();
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        for (int b = 0; b < stop_after; b++) begin
            repeat (gap) tick();
            mem_rdata_i  = beats[16*b +: 16];
            mem_rvalid_i = 1'b1;
            tick();
            mem_rvalid_i = 1'b0;
        end
        if (stop_after == 8) begin
            #1;
            check("burst_push_enq", reader_burst_enq_o, 1'b1);
            check("burst_push_data", reader_burst_d_o, beats);
            exp_burst++;
            tick();
        end
    endtask

    task check_stats(input string name);
`ifdef FB_MEM_RESPONDER_STATS_EN
        check({name, "_stat_single"}, stat_single_o, 16'(exp_single));
        check({name, "_stat_burst"}, stat_burst_o, 16'(exp_burst));
`else
        checks = checks + 0;
`endif
    endtask

    initial begin
        int r0;
        int e0;
        int b0;

        vecs[0] = '{1'b1, 24'h000010, 16'hABCD, 2, 16'h0000, 0, 3, 0, 16'h0000};
        vecs[1] = '{1'b0, 24'h000020, 16'h0000, 0, 16'h1234, 1, 1, 1, 16'h1234};
        vecs[2] = '{1'b1, 24'hFFFFFF, 16'hFFFF, 0, 16'h0000, 0, 1, 0, 16'h0000};
        vecs[3] = '{1'b0, 24'h000000, 16'h0000, 3, 16'hBEEF, 0, 4, 1, 16'hBEEF};
        vecs[4] = '{1'b1, 24'h123456, 16'h0000, 1, 16'h0000, 0, 2, 0, 16'h0000};

        // Reset with a pending command that must not be popped.
        reset_i              = 1'b1;
        writer_q_i           = {1'b1, 24'h000099, 16'h9999};
        writer_empty_i       = 1'b0;
        writer_burst_q_i     = '0;
        writer_burst_empty_i = 1'b1;
        reader_full_i        = 1'b0;
        reader_burst_full_i  = 1'b0;
        mem_ack_i            = 1'b0;
        mem_rvalid_i         = 1'b0;
        mem_rdata_i          = '0;
        tick();
        tick();
        check_all_zero("reset");
        check_stats("reset");
        writer_empty_i = 1'b1;
        reset_i        = 1'b0;
        tick();

        // Table of single transactions.
        for (int i = 0; i < 5; i++) begin
            r0 = req_cycles;
            e0 = enq_cnt;
            do_single(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ack_delay,
                      vecs[i].rdata, vecs[i].rv_delay);
            if (vecs[i].we) begin
                mem_rvalid_i = 1'b1;
                mem_ack_i    = 1'b1;
                mem_rdata_i  = 16'hDEAD;
                tick();
                mem_rvalid_i = 1'b0;
                mem_ack_i    = 1'b0;
            end
            tick();
            tick();
            check($sformatf("vec%0d_req_cycles", i), req_cycles - r0, vecs[i].exp_req);
            check($sformatf("vec%0d_enq_count", i), enq_cnt - e0, vecs[i].exp_enq);
            if (!vecs[i].we) begin
                check($sformatf("vec%0d_rd_data", i), last_rd, vecs[i].exp_rd);
            end
        end

        // Back-to-back writes: IDLE, REQ (acked), IDLE again.
        writer_q_i     = {1'b1, 24'h000100, 16'h1111};
        writer_empty_i = 1'b0;
        #1;
        check("lat_first_deq", writer_deq_o, 1'b1);
        tick();
        writer_q_i = {1'b1, 24'h000200, 16'h2222};
        mem_ack_i  = 1'b1;
        #1;
        check("lat_first_req", {mem_req_o, mem_addr_o, mem_wdata_o}, {1'b1, 24'h000100, 16'h1111});
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("lat_second_deq", {mem_req_o, writer_deq_o}, 2'b01);
        tick();
        writer_empty_i = 1'b1;
        check("lat_second_req", {mem_req_o, mem_addr_o, mem_wdata_o}, {1'b1, 24'h000200, 16'h2222});
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        exp_single += 2;
        tick();

        // Burst read with gaps between beats.
        b0 = benq_cnt;
        run_burst(24'h800000, 128'h00080007000600050004000300020001, 1, 1, 8);
        tick();
        check("burst_enq_count", benq_cnt - b0, 1);
        check("burst_last_word", last_burst, 128'h00080007000600050004000300020001);

        // Both command FIFOs non-empty: burst wins, single follows.
        writer_q_i           = {1'b1, 24'h000055, 16'h5555};
        writer_empty_i       = 1'b0;
        writer_burst_q_i     = {8'h00, 24'h800100};
        writer_burst_empty_i = 1'b0;
        #1;
        check("prio_burst_first", {writer_burst_deq_o, writer_deq_o}, 2'b10);
        run_burst(24'h800100, 128'h0F0E0D0C0B0A09080706050403020100, 0, 0, 8);
        do_single(1'b1, 24'h000055, 16'h5555, 0, 16'h0000, 0);
        tick();

        // Burst destination full: the pending write goes first, burst waits.
        reader_burst_full_i  = 1'b1;
        writer_burst_q_i     = {8'h00, 24'h800200};
        writer_burst_empty_i = 1'b0;
        writer_q_i           = {1'b1, 24'h000066, 16'h6666};
        writer_empty_i       = 1'b0;
        #1;
        check("full_single_first", {writer_burst_deq_o, writer_deq_o}, 2'b01);
        do_single(1'b1, 24'h000066, 16'h6666, 0, 16'h0000, 0);
        tick();
        tick();
        check("full_burst_held", {writer_burst_deq_o, mem_req_o}, 2'b00);
        reader_burst_full_i = 1'b0;
        b0 = benq_cnt;
        run_burst(24'h800200, 128'hAAAA9999888877776666555544443333, 0, 2, 8);
        tick();
        check("full_burst_enq_count", benq_cnt - b0, 1);

        // Single read blocked while the single-read FIFO is full.
        writer_q_i     = {1'b0, 24'h000077, 16'h0000};
        writer_empty_i = 1'b0;
        reader_full_i  = 1'b1;
        #1;
        check("rdfull_no_deq", writer_deq_o, 1'b0);
        tick();
        tick();
        check("rdfull_still_idle", {writer_deq_o, mem_req_o}, 2'b00);
        reader_full_i = 1'b0;
        do_single(1'b0, 24'h000077, 16'h0000, 0, 16'hC0DE, 2);
        tick();
        check("rdfull_rd_data", last_rd, 16'hC0DE);
        check_stats("mid");

        // Reset in the middle of a burst, after three beats.
        b0 = benq_cnt;
        run_burst(24'h812345, 128'h11112222333344445555666677778888, 0, 0, 3);
        reset_i      = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 16'h4444;
        tick();
        tick();
        check_all_zero("midreset");
        exp_single = 0;
        exp_burst  = 0;
        check_stats("midreset");
        reset_i      = 1'b0;
        mem_rvalid_i = 1'b0;
        repeat (4) tick();
        check("midreset_no_push", benq_cnt - b0, 0);
        run_burst(24'h800300, 128'h0123456789ABCDEF0011223344556677, 0, 0, 8);
        tick();
        check("after_reset_burst", last_burst, 128'h0123456789ABCDEF0011223344556677);
        check_stats("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_mem_responder.md
FB_MEM_RESPONDER -- requirements
Module: fb_mem_responder

Interface
REQ-001 Parameter: BURST_LEN, 8, 16-bit beats per burst read; fixed at 8 so that 8x16 = 128-bit reader burst word.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 writer_q_i  input  41  single command: [40]=we, [39:16]=word addr, [15:0]=write data.
REQ-005 writer_deq_o  output  1  pop single-command FIFO; writer_empty_i  input  1  single-command FIFO empty.
REQ-006 writer_burst_q_i  input  32  burst read request: [23:0]=start word addr, [31:24] ignored.
REQ-007 writer_burst_deq_o  output  1  pop burst FIFO; writer_burst_empty_i  input  1  burst FIFO empty.
REQ-008 reader_d_o  output  16  single read data; reader_enq_o  output  1  push; reader_full_i  input  1  single-read FIFO full.
REQ-009 reader_burst_d_o  output  128  burst data; reader_burst_enq_o  output  1  push; reader_burst_full_i  input  1  burst-read FIFO full.
REQ-010 mem_req_o  output  1  memory request; mem_we_o  output  1  write; mem_burst_o  output  1  burst read; mem_addr_o  output  24; mem_wdata_o  output  16.
REQ-011 mem_ack_i  input  1  request accepted; mem_rvalid_i  input  1  read beat valid; mem_rdata_i  input  16  read beat.

Function
REQ-012 All FIFOs are first-word-fall-through: q valid whenever !empty; a deq pulse pops exactly one entry; deq/enq are single-cycle pulses.
REQ-013 States: IDLE, REQ, WAIT_SINGLE, COLLECT, PUSH_BURST.
REQ-014 IDLE arbitration, burst priority: burst chosen if !writer_burst_empty_i && !reader_burst_full_i; else single chosen if !writer_empty_i and (we=1 or !reader_full_i); else stay IDLE.
REQ-015 On selection in IDLE: latch command into request registers, pulse matching deq for that one cycle, go REQ next cycle.
REQ-016 REQ: mem_req_o=1 with latched mem_we_o/mem_burst_o/mem_addr_o/mem_wdata_o held stable until the cycle mem_ack_i=1; mem_req_o=0 the following cycle.
REQ-017 On ack: write -> IDLE; single read -> WAIT_SINGLE; burst -> COLLECT with beat counter=0.
REQ-018 WAIT_SINGLE: on mem_rvalid_i, reader_d_o<=mem_rdata_i and reader_enq_o=1 next cycle, -> IDLE.
REQ-019 COLLECT: each mem_rvalid_i beat n (0..7) stored at reader_burst_d_o[16n+15:16n]; after beat 7 -> PUSH_BURST.
REQ-020 PUSH_BURST: reader_burst_enq_o=1 for one cycle with full 128-bit word, -> IDLE.
REQ-021 Destination space is checked only in IDLE; block is sole producer, so space is guaranteed at push time.
REQ-022 mem_rvalid_i outside WAIT_SINGLE/COLLECT is ignored; mem_ack_i outside REQ is ignored.
REQ-023 Both FIFOs non-empty simultaneously: burst served first; single served next IDLE pass if no eligible burst.
REQ-024 Minimum IDLE-to-IDLE write latency: 3 cycles with ack in first REQ cycle.

Reset
REQ-025 reset_i=1 forces IDLE; all outputs 0, including reader_burst_d_o, mem_addr_o, mem_wdata_o.
REQ-026 Reset mid-transaction abandons it with no enq; the memory controller is reset by the same reset_i.

Configuration
REQ-027 Macro FB_MEM_RESPONDER_STATS_EN: when defined, add outputs stat_single_o(16) and stat_burst_o(16), saturating counts of completed single and burst transactions, cleared by reset; when undefined, ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-028 Single write {1,24'h000010,16'hABCD}, ack after 2 cycles -> one mem_req with addr 0x000010, wdata 0xABCD, no reader_enq_o.
REQ-029 Single read addr 0x000020, rvalid data 0x1234 -> one reader_enq_o with reader_d_o=0x1234.
REQ-030 Burst addr 0x800000, beats 0x0001..0x0008 -> reader_burst_d_o=0x00080007000600050004000300020001, one enq pulse.
REQ-031 Both FIFOs non-empty in same cycle -> writer_burst_deq_o before writer_deq_o; mem_burst_o=1 on first request.
REQ-032 reader_burst_full_i=1 with pending burst, pending single write -> write serviced, burst held until full deasserts.
REQ-033 reset_i asserted during COLLECT after 3 beats -> IDLE, no reader_burst_enq_o, outputs 0; with STATS_EN, counters read 0.
